elink_frame_assembler: RTL and testbench

Receive-side framing stage that takes the decoded 8-bit e-link byte stream with its 2-bit delimiter code, as produced by the 8b10b e-link decoder path of the EMCI emulator and MOPSHUB e-link receiver, and packs one SOP…EOP packet into a 76-bit frame. Each complete frame is presented on a valid/ready output toward the receive FIFO write side. Malformed packets are dropped and flagged. Runs entirely in the bitCLK domain, directly downstream of the e-link decoder.

---
 rtl/mopshub_elink_pkg.sv | 27 ++
 rtl/elink_frame_assembler.sv | 170 +++++++++++++++++
 tb/tb_elink_frame_assembler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mopshub_elink_pkg.sv
// Shared definitions for the e-link receive path: delimiter codes, frame
// geometry, error-counter width and the frame assembler FSM states.
package mopshub_elink_pkg;

  // Delimiter codes qualified by the byte strobe
  localparam logic [1:0] DELIM_DATA  = 2'b00;
  localparam logic [1:0] DELIM_SOP   = 2'b10;
  localparam logic [1:0] DELIM_EOP   = 2'b01;
  localparam logic [1:0] DELIM_COMMA = 2'b11;

  // Frame geometry: 10 bytes collected, low 76 bits form the frame
  localparam int FRAME_BYTES = 10;
  localparam int FRAME_BITS  = 76;

  // Width of the saturating error counter
  localparam int CNT_W = 8;

  // Byte counter is 4 bits wide and saturates at FRAME_BYTES
  localparam logic [3:0] BYTE_CNT_FULL = 4'(FRAME_BYTES);

  // Frame assembler FSM states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/elink_frame_assembler.sv
// elink_frame_assembler: packs one SOP..EOP packet of decoded e-link bytes
// into a 76-bit frame and offers it on a valid/ready output register.
// Malformed packets are dropped and flagged with one-cycle error pulses.
// Optional feature: define ELINK_ASM_ERRCNT_EN to add the saturating err_cnt
// port and its counter.
module elink_frame_assembler
  import mopshub_elink_pkg::*;
(
  input  logic                  bitCLK,
  input  logic                  rst,
  input  logic [7:0]            data_in_8bit,
  input  logic [1:0]            delim_in,
  input  logic                  data_in_en,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_overflow
`ifdef ELINK_ASM_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]      err_cnt
`endif
);

  asm_state_e            state_q, state_d;
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic                  long_flag_q, long_flag_d;
  // Only the low 76 bits of the 80-bit collection window ever reach the
  // frame, so the top nibble of the first byte is never stored.
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  commit;
  logic                  strobe;

  // Commas are invisible in every state, so they never form a strobe
  assign strobe = data_in_en && (delim_in != DELIM_COMMA);

  // Next-state, collection and output-register logic
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    long_flag_d    = long_flag_q;
    shift_d        = shift_q;
    frame_d        = frame_q;
    frame_valid_d  = frame_valid_q && !frame_ready;
    err_short_d    = 1'b0;
    err_long_d     = 1'b0;
    err_overflow_d = 1'b0;
    commit         = 1'b0;

    if (strobe) begin
      unique case (state_q)
        ST_IDLE: begin
          // Stray data/EOP outside a packet is silently ignored
          if (delim_in == DELIM_SOP) begin
            state_d     = ST_COLLECT;
            byte_cnt_d  = 4'd0;
            long_flag_d = 1'b0;
          end
        end
        ST_COLLECT: begin
          unique case (delim_in)
            DELIM_DATA: begin
              if (byte_cnt_q < BYTE_CNT_FULL) begin
                shift_d    = {shift_q[FRAME_BITS-9:0], data_in_8bit};
                byte_cnt_d = byte_cnt_q + 4'd1;
              end else begin
                long_flag_d = 1'b1;
              end
            end
            DELIM_EOP: begin
              if ((byte_cnt_q == BYTE_CNT_FULL) && !long_flag_q) begin
                commit = 1'b1;
              end else if (long_flag_q) begin
                err_long_d = 1'b1;
              end else begin
                err_short_d = 1'b1;
              end
              state_d = ST_IDLE;
            end
            DELIM_SOP: begin
              // Restart: the partial packet is discarded
              err_short_d = 1'b1;
              byte_cnt_d  = 4'd0;
              long_flag_d = 1'b0;
            end
            default: ;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A good frame loads only if the holding register is free this cycle
    if (commit) begin
      if (!frame_valid_q || frame_ready) begin
        frame_d       = shift_q;
        frame_valid_d = 1'b1;
      end else begin
        err_overflow_d = 1'b1;
      end
    end
  end

  // State, data and pulse registers
  always_ff @(posedge bitCLK) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      byte_cnt_q     <= 4'd0;
      long_flag_q    <= 1'b0;
      shift_q        <= '0;
      frame_q        <= '0;
      frame_valid_q  <= 1'b0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      long_flag_q    <= long_flag_d;
      shift_q        <= shift_d;
      frame_q        <= frame_d;
      frame_valid_q  <= frame_valid_d;
      err_short_q    <= err_short_d;
      err_long_q     <= err_long_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign frame_out    = frame_q;
  assign frame_valid  = frame_valid_q;
  assign busy         = (state_q == ST_COLLECT);
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign err_overflow = err_overflow_q;

`ifdef ELINK_ASM_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             any_err;

  // Counter steps with the pulses it counts; coincident pulses count once
  assign any_err = err_short_d || err_long_d || err_overflow_d;

  // Saturating error count
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (any_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register
  always_ff @(posedge bitCLK) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_elink_frame_assembler.sv
// Self-checking bench for elink_frame_assembler. A packet-level reference
// model (byte list per packet, frame built from the first ten bytes) predicts
// every output each cycle. Build with ELINK_ASM_ERRCNT_EN to cover err_cnt.
module tb_elink_frame_assembler;

  localparam logic [1:0] D_DATA  = 2'b00;
  localparam logic [1:0] D_SOP   = 2'b10;
  localparam logic [1:0] D_EOP   = 2'b01;
  localparam logic [1:0] D_COMMA = 2'b11;

  logic        bitCLK = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in_8bit = '0;
  logic [1:0]  delim_in = '0;
  logic        data_in_en = 1'b0;
  logic [75:0] frame_out;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        busy;
  logic        err_short;
  logic        err_long;
  logic        err_overflow;
`ifdef ELINK_ASM_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  elink_frame_assembler dut (
    .bitCLK       (bitCLK),
    .rst          (rst),
    .data_in_8bit (data_in_8bit),
    .delim_in     (delim_in),
    .data_in_en   (data_in_en),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .err_short    (err_short),
    .err_long     (err_long),
    .err_overflow (err_overflow)
`ifdef ELINK_ASM_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 bitCLK = ~bitCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Reference model state
  bit          m_in_pkt;
  int          m_cnt;
  logic [7:0]  m_bytes [10];
  bit          m_valid;
  logic [75:0] m_frame;
  int          m_errcnt;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame = concatenation of the ten data bytes, first byte most significant,
  // truncated to the low 76 bits.
  function automatic logic [75:0] pack_frame();
    logic [79:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) w = {w[71:0], m_bytes[i]};
    return w[75:0];
  endfunction

  task automatic model_reset();
    m_in_pkt = 0;
    m_cnt    = 0;
    m_valid  = 0;
    m_frame  = '0;
    m_errcnt = 0;
  endtask

  // One clock cycle: apply inputs, predict, step, compare
  task automatic drive(input bit en, input logic [1:0] dl, input logic [7:0] d, input bit rdy);
    bit e_short, e_long, e_ovf, good;
    bit next_valid;
    e_short = 0; e_long = 0; e_ovf = 0; good = 0;
    data_in_en   = en;
    delim_in     = dl;
    data_in_8bit = d;
    frame_ready  = rdy;

    if (en && dl != D_COMMA) begin
      if (!m_in_pkt) begin
        if (dl == D_SOP) begin
          m_in_pkt = 1;
          m_cnt    = 0;
        end
      end else begin
        case (dl)
          D_DATA: begin
            if (m_cnt < 10) m_bytes[m_cnt] = d;
            if (m_cnt < 1000) m_cnt++;
          end
          D_EOP: begin
            m_in_pkt = 0;
            if (m_cnt == 10) good = 1;
            else if (m_cnt > 10) e_long = 1;
            else e_short = 1;
          end
          default: begin
            e_short = 1;
            m_cnt   = 0;
          end
        endcase
      end
    end

    next_valid = m_valid && !rdy;
    if (good) begin
      if (!m_valid || rdy) begin
        m_frame    = pack_frame();
        next_valid = 1;
        n_frames++;
        $display("frame %0d loaded: %h", n_frames, m_frame);
      end else begin
        e_ovf = 1;
      end
    end
    m_valid = next_valid;
    if ((e_short || e_long || e_ovf) && m_errcnt < 255) m_errcnt++;

    @(posedge bitCLK);
    #1;
    check_val("busy",         {79'd0, busy},         {79'd0, m_in_pkt});
    check_val("frame_valid",  {79'd0, frame_valid},  {79'd0, m_valid});
    check_val("frame_out",    {4'd0, frame_out},     {4'd0, m_frame});
    check_val("err_short",    {79'd0, err_short},    {79'd0, e_short});
    check_val("err_long",     {79'd0, err_long},     {79'd0, e_long});
    check_val("err_overflow", {79'd0, err_overflow}, {79'd0, e_ovf});
`ifdef ELINK_ASM_ERRCNT_EN
    check_val("err_cnt",      {72'd0, err_cnt},      80'(m_errcnt));
`endif
  endtask

  task automatic do_reset();
    rst = 1;
    data_in_en = 0;
    frame_ready = 0;
    @(posedge bitCLK); @(posedge bitCLK);
    #1;
    model_reset();
    check_val("rst_frame_valid", {79'd0, frame_valid}, 80'd0);
    check_val("rst_frame_out",   {4'd0, frame_out},    80'd0);
    check_val("rst_busy",        {79'd0, busy},        80'd0);
    check_val("rst_errs",        {77'd0, err_short, err_long, err_overflow}, 80'd0);
`ifdef ELINK_ASM_ERRCNT_EN
    check_val("rst_err_cnt",     {72'd0, err_cnt},     80'd0);
`endif
    rst = 0;
  endtask

  // SOP, n data bytes (base+i or random), optional commas, EOP
  task automatic send_pkt(input int n, input int base, input bit rnd, input bit rdy, input int comma_pct);
    drive(1, D_SOP, 8'h00, rdy);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < comma_pct) drive(1, D_COMMA, 8'($urandom), rdy);
      drive(1, D_DATA, rnd ? 8'($urandom) : 8'(base + i), rdy);
    end
    if ($urandom_range(0, 99) < comma_pct) drive(1, D_COMMA, 8'hBC, rdy);
    drive(1, D_EOP, 8'h00, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 2'($urandom), 8'($urandom), rdy);
  endtask

  localparam logic [75:0] TP_FRAME = 76'h1_0203_0405_0607_0809_0A;
  logic [75:0] held;

  initial begin
    model_reset();
    do_reset();

    // Good packet
    send_pkt(10, 1, 0, 1, 0);
    check_val("tp_good", {4'd0, frame_out}, {4'd0, TP_FRAME});
    idle(2, 1);

    // Short packet then good packet
    send_pkt(9, 1, 0, 1, 0);
    send_pkt(10, 1, 0, 1, 0);
    check_val("tp_after_short", {4'd0, frame_out}, {4'd0, TP_FRAME});
    idle(1, 1);

    // Long packet, then SOP-restart after 5 bytes
    send_pkt(12, 1, 0, 1, 0);
    drive(1, D_SOP, 8'h00, 1);
    for (int i = 0; i < 5; i++) drive(1, D_DATA, 8'hE0 + 8'(i), 1);
    send_pkt(10, 1, 0, 1, 0);
    check_val("tp_restart", {4'd0, frame_out}, {4'd0, TP_FRAME});
    idle(1, 1);

    // Backpressure: two back-to-back packets with frame_ready low
    send_pkt(10, 8'h21, 0, 0, 0);
    held = frame_out;
    send_pkt(10, 8'h41, 0, 0, 0);
    check_val("tp_bp_held", {4'd0, frame_out}, {4'd0, held});
    idle(3, 1);
    check_val("tp_bp_released", {79'd0, frame_valid}, 80'd0);

    // Commas inside a packet and stray data in IDLE
    drive(1, D_DATA, 8'h55, 1);
    drive(1, D_EOP, 8'h00, 1);
    send_pkt(10, 1, 0, 1, 50);
    check_val("tp_commas", {4'd0, frame_out}, {4'd0, TP_FRAME});
    idle(1, 1);

    // Reset mid-packet, then a full packet
    drive(1, D_SOP, 8'h00, 1);
    for (int i = 0; i < 4; i++) drive(1, D_DATA, 8'hF0 + 8'(i), 1);
    do_reset();
    send_pkt(10, 8'h61, 0, 1, 0);
    idle(1, 1);

    // Randomized packets: mostly good, some short/long, random ready
    for (int p = 0; p < 200; p++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) send_pkt(9, 0, 1, $urandom_range(0, 3) != 0, 10);
      else if (r == 1) send_pkt(11 + $urandom_range(0, 2), 0, 1, $urandom_range(0, 3) != 0, 10);
      else send_pkt(10, 0, 1, $urandom_range(0, 3) != 0, 10);
      for (int k = $urandom_range(0, 2); k > 0; k--) drive($urandom_range(0, 1), 2'($urandom), 8'($urandom), $urandom_range(0, 1));
    end

    // Fully random strobes with a delimiter mix
    for (int c = 0; c < 1500; c++) begin
      int r;
      logic [1:0] dl;
      r  = $urandom_range(0, 19);
      dl = (r < 14) ? D_DATA : (r < 16) ? D_SOP : (r < 18) ? D_EOP : D_COMMA;
      drive($urandom_range(0, 7) != 0, dl, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(2, 1);

`ifdef ELINK_ASM_ERRCNT_EN
    do_reset();
    for (int p = 0; p < 300; p++) send_pkt(9, 0, 1, 1, 0);
    check_val("tp_errcnt_sat", {72'd0, err_cnt}, 80'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
